// File: rtl/alu_share.sv
// alu_share: round-robin arbiter that time-shares one combinational ALU
// between the integer execute stage (requester 0) and the address/branch
// compare unit (requester 1). Results land in a one-entry tagged output
// register; accepted operations are counted per requester.
module alu_share #(
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [31:0]     r0_a,
  input  logic [31:0]     r0_b,
  input  logic [2:0]      r0_op,
  input  logic            r0_ctrl,
  input  logic            r0_lt,
  input  logic            r0_ltu,

  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [31:0]     r1_a,
  input  logic [31:0]     r1_b,
  input  logic [2:0]      r1_op,
  input  logic            r1_ctrl,
  input  logic            r1_lt,
  input  logic            r1_ltu,

  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_ctrl,
  output logic            alu_lt,
  output logic            alu_ltu,
  input  logic [31:0]     alu_result,

  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [31:0]     rsp_result,

  output logic [CNTW-1:0] cnt0,
  output logic [CNTW-1:0] cnt1
);

  // Requester that received the most recent grant; reset to 1 so that
  // requester 0 wins the first contended cycle.
  logic last;
  logic space;
  logic g0;
  logic g1;
  logic gnt;
  logic gid;

  // Grant selection: depends only on space, the valids and last, never on operands.
  always_comb begin
    space = ~rsp_valid | rsp_ready;
    g0    = space & r0_valid & (~r1_valid | last);
    g1    = space & r1_valid & (~r0_valid | ~last);
    gnt   = g0 | g1;
    gid   = g1;
  end

  assign r0_ready = g0;
  assign r1_ready = g1;

  // Operand steering onto the shared ALU; idle cycles drive all zeros.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    alu_ctrl = 1'b0;
    alu_lt   = 1'b0;
    alu_ltu  = 1'b0;
    if (g0) begin
      alu_a    = r0_a;
      alu_b    = r0_b;
      alu_op   = r0_op;
      alu_ctrl = r0_ctrl;
      alu_lt   = r0_lt;
      alu_ltu  = r0_ltu;
    end else if (g1) begin
      alu_a    = r1_a;
      alu_b    = r1_b;
      alu_op   = r1_op;
      alu_ctrl = r1_ctrl;
      alu_lt   = r1_lt;
      alu_ltu  = r1_ltu;
    end
  end

  // Output register, fairness pointer and counters. A grant in the same
  // cycle as a drain overwrites the entry, so rsp_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      last       <= 1'b1;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      if (gnt) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= gid;
        rsp_result <= alu_result;
        last       <= gid;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
      if (g0) cnt0 <= cnt0 + CNTW'(1);
      if (g1) cnt1 <= cnt1 + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_alu_share.sv
// Self-checking bench for alu_share: a cycle model of the arbiter/buffer is
// compared against the DUT every cycle, with literal expectations from the
// directed scenarios layered on top. A second instance with CNTW=4 shares
// the stimulus to exercise counter wrap.
module tb_alu_share;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ctrl, r0_lt, r0_ltu;
  logic [31:0] r0_a, r0_b;
  logic [2:0]  r0_op;
  logic        r1_valid, r1_ctrl, r1_lt, r1_ltu;
  logic [31:0] r1_a, r1_b;
  logic [2:0]  r1_op;
  logic        rsp_ready;

  logic        r0_ready, r1_ready;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_ctrl, alu_lt, alu_ltu;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_result;
  logic [15:0] cnt0, cnt1;

  logic        w_r0_ready, w_r1_ready;
  logic [31:0] w_alu_a, w_alu_b, w_alu_result;
  logic [2:0]  w_alu_op;
  logic        w_alu_ctrl, w_alu_lt, w_alu_ltu;
  logic        w_rsp_valid, w_rsp_id;
  logic [31:0] w_rsp_result;
  logic [3:0]  w_cnt0, w_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Reference RV32 ALU (func3 encoding, bit 30 as ctrl).
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic ctrl,
                                        input logic lt, input logic ltu);
    case (op)
      3'd0:    return ctrl ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, lt};
      3'd3:    return {31'd0, ltu};
      3'd4:    return a ^ b;
      3'd5:    return ctrl ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_a, alu_b, alu_op, alu_ctrl, alu_lt, alu_ltu);
  assign w_alu_result = alu_f(w_alu_a, w_alu_b, w_alu_op, w_alu_ctrl, w_alu_lt, w_alu_ltu);

  alu_share dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_op(r0_op), .r0_ctrl(r0_ctrl), .r0_lt(r0_lt), .r0_ltu(r0_ltu),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_op(r1_op), .r1_ctrl(r1_ctrl), .r1_lt(r1_lt), .r1_ltu(r1_ltu),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ctrl(alu_ctrl),
    .alu_lt(alu_lt), .alu_ltu(alu_ltu), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .cnt0(cnt0), .cnt1(cnt1)
  );

  alu_share #(.CNTW(4)) dut_w (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(w_r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_op(r0_op), .r0_ctrl(r0_ctrl), .r0_lt(r0_lt), .r0_ltu(r0_ltu),
    .r1_valid(r1_valid), .r1_ready(w_r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_op(r1_op), .r1_ctrl(r1_ctrl), .r1_lt(r1_lt), .r1_ltu(r1_ltu),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_op(w_alu_op), .alu_ctrl(w_alu_ctrl),
    .alu_lt(w_alu_lt), .alu_ltu(w_alu_ltu), .alu_result(w_alu_result),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w_rsp_id),
    .rsp_result(w_rsp_result), .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic        m_valid;
  logic        m_id;
  logic [31:0] m_res;
  int          m_last;
  logic [31:0] m_cnt0, m_cnt1;

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_res = '0; m_last = 1; m_cnt0 = '0; m_cnt1 = '0;
  endtask

  // Which requester should win this cycle (-1 = none).
  function automatic int exp_grant();
    if (m_valid && !rsp_ready) return -1;
    if (r0_valid && r1_valid) return (m_last == 0) ? 1 : 0;
    if (r0_valid) return 0;
    if (r1_valid) return 1;
    return -1;
  endfunction

  initial begin
    int g;
    @(posedge clk);
    model_reset();
    forever begin
      @(negedge clk);
      g = exp_grant();
      chk("m_r0_ready", 32'(r0_ready), 32'(g == 0));
      chk("m_r1_ready", 32'(r1_ready), 32'(g == 1));
      chk("m_alu_a",  alu_a,  g == 0 ? r0_a : g == 1 ? r1_a : 32'd0);
      chk("m_alu_b",  alu_b,  g == 0 ? r0_b : g == 1 ? r1_b : 32'd0);
      chk("m_alu_op", 32'(alu_op), g == 0 ? 32'(r0_op) : g == 1 ? 32'(r1_op) : 32'd0);
      chk("m_alu_flags", 32'({alu_ctrl, alu_lt, alu_ltu}),
          g == 0 ? 32'({r0_ctrl, r0_lt, r0_ltu}) : g == 1 ? 32'({r1_ctrl, r1_lt, r1_ltu}) : 32'd0);
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
      chk("m_rsp_result", rsp_result, m_res);
      chk("m_cnt0", 32'(cnt0), 32'(m_cnt0[15:0]));
      chk("m_cnt1", 32'(cnt1), 32'(m_cnt1[15:0]));
      chk("m_w_cnt0", 32'(w_cnt0), 32'(m_cnt0[3:0]));
      chk("m_w_cnt1", 32'(w_cnt1), 32'(m_cnt1[3:0]));
      @(posedge clk);
      if (rst) model_reset();
      else if (g >= 0) begin
        m_valid = 1'b1;
        m_id    = (g == 1);
        m_last  = g;
        if (g == 0) begin
          m_res = alu_f(r0_a, r0_b, r0_op, r0_ctrl, r0_lt, r0_ltu);
          m_cnt0++;
        end else begin
          m_res = alu_f(r1_a, r1_b, r1_op, r1_ctrl, r1_lt, r1_ltu);
          m_cnt1++;
        end
      end else if (m_valid && rsp_ready) m_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic c);
    r0_valid = v; r0_a = a; r0_b = b; r0_op = op; r0_ctrl = c; r0_lt = 1'b0; r0_ltu = 1'b0;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic c);
    r1_valid = v; r1_a = a; r1_b = b; r1_op = op; r1_ctrl = c; r1_lt = 1'b0; r1_ltu = 1'b0;
  endtask

  initial begin
    logic s0, s1;
    rst = 1'b1; rsp_ready = 1'b1;
    set0(1'b0, '0, '0, 3'd0, 1'b0);
    set1(1'b0, '0, '0, 3'd0, 1'b0);
    step(); step();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_readys", 32'({r0_ready, r1_ready}), 32'd0);

    // single subtract: 5 - 3
    step();
    set0(1'b1, 32'd5, 32'd3, 3'd0, 1'b1);
    @(negedge clk);
    chk("t1_r0_ready", 32'(r0_ready), 32'd1);
    step();
    set0(1'b0, '0, '0, 3'd0, 1'b0);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_rsp_result", rsp_result, 32'd2);
    chk("t1_cnt0", 32'(cnt0), 32'd1);

    // contention after a fresh reset: grants 0,1,0,1,0,1
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    set0(1'b1, 32'd1, 32'd2, 3'd0, 1'b0);
    set1(1'b1, 32'hF0, 32'h0F, 3'd6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_r0_ready", 32'(r0_ready), 32'(i % 2 == 0));
      chk("t2_r1_ready", 32'(r1_ready), 32'(i % 2 == 1));
      if (i > 0) chk("t2_result", rsp_result, (i % 2 == 1) ? 32'd3 : 32'hFF);
      step();
    end
    set0(1'b0, '0, '0, 3'd0, 1'b0);
    set1(1'b0, '0, '0, 3'd0, 1'b0);
    @(negedge clk);
    chk("t2_last_result", rsp_result, 32'hFF);
    chk("t2_cnt0", 32'(cnt0), 32'd3);
    chk("t2_cnt1", 32'(cnt1), 32'd3);

    // backpressure, then drain+grant in one cycle (r1 shift)
    step();
    set0(1'b1, 32'd7, 32'd1, 3'd0, 1'b0);
    @(negedge clk);
    chk("t3_accept", 32'(r0_ready), 32'd1);
    step();
    rsp_ready = 1'b0;
    set0(1'b1, 32'd10, 32'd10, 3'd0, 1'b0);
    set1(1'b1, 32'h80000000, 32'd4, 3'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_readys", 32'({r0_ready, r1_ready}), 32'd0);
      chk("t3_result_hold", rsp_result, 32'd8);
      chk("t3_alu_idle", alu_a | alu_b | 32'(alu_op), 32'd0);
      chk("t3_cnt0_hold", 32'(cnt0), 32'd4);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_r1_ready", 32'(r1_ready), 32'd1);
    chk("t3_valid_before", 32'(rsp_valid), 32'd1);
    step();
    set1(1'b0, '0, '0, 3'd0, 1'b0);
    @(negedge clk);
    chk("t4_valid", 32'(rsp_valid), 32'd1);
    chk("t4_rsp_id", 32'(rsp_id), 32'd1);
    chk("t4_sra", rsp_result, 32'hF8000000);
    step();
    set0(1'b0, '0, '0, 3'd0, 1'b0);
    @(negedge clk);
    chk("t3_second", rsp_result, 32'd20);

    // reset mid-stream while a result is buffered
    step();
    set0(1'b1, 32'd1, 32'd1, 3'd0, 1'b0);
    @(negedge clk);
    step();
    set0(1'b0, '0, '0, 3'd0, 1'b0);
    rsp_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t5_valid_pre", 32'(rsp_valid), 32'd1);
    step();
    rst = 1'b0; rsp_ready = 1'b1;
    set0(1'b1, 32'd2, 32'd2, 3'd0, 1'b0);
    set1(1'b1, 32'd3, 32'd3, 3'd0, 1'b0);
    @(negedge clk);
    chk("t5_valid", 32'(rsp_valid), 32'd0);
    chk("t5_cnts", 32'({cnt0, cnt1}), 32'd0);
    chk("t5_r0_wins", 32'({r0_ready, r1_ready}), 32'b10);
    step();
    set0(1'b0, '0, '0, 3'd0, 1'b0);
    @(negedge clk);
    chk("t5_res0", rsp_result, 32'd4);
    step();
    set1(1'b0, '0, '0, 3'd0, 1'b0);
    @(negedge clk);
    chk("t5_res1", rsp_result, 32'd6);

    // counter wrap: 17 r0 ops on the CNTW=4 instance
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set0(1'b1, 32'(i * 32'h01234567), 32'(i * 3), 3'(i), 1'(i));
      r0_lt = 1'(i >> 1); r0_ltu = 1'(i >> 2);
      @(negedge clk);
      step();
    end
    set0(1'b0, '0, '0, 3'd0, 1'b0);
    @(negedge clk);
    chk("t6_wrap_cnt0", 32'(w_cnt0), 32'd1);
    chk("t6_cnt0", 32'(cnt0), 32'd17);

    // mixed traffic with intermittent backpressure; requesters hold until accepted
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      s0 = r0_ready; s1 = r1_ready;
      step();
      if (!r0_valid || s0) begin
        set0(1'((i % 4) != 1), 32'(i * 32'h9E3779B9), 32'(i * 7), 3'(i * 3), 1'(i >> 1));
        r0_lt = 1'(i); r0_ltu = 1'(i >> 2);
      end
      if (!r1_valid || s1) begin
        set1(1'((i % 3) != 0), 32'(~(i * 32'h00010203)), 32'(i + 5), 3'(i * 5 + 1), 1'(i));
        r1_lt = 1'(i >> 1); r1_ltu = 1'(i);
      end
      rsp_ready = 1'((i % 5) != 3);
    end
    set0(1'b0, '0, '0, 3'd0, 1'b0);
    set1(1'b0, '0, '0, 3'd0, 1'b0);
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
